// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester round-robin arbiter that owns the select of a
// WIDTH-bit 2:1 datapath mux. A requester that wins keeps the mux until it
// drops its request. When both want it from idle, the one that did not own it
// last wins.
//
// Optional feature (macro ARB_TIMEOUT_EN): an owner that has held the mux for
// MAX_HOLD cycles while the other side is waiting is forced to hand over.
// Without the macro there is no preemption and the hold counter is not built.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   req_a/b    level requests, held while the mux is in use
//   a/b        WIDTH-bit data from requester A/B
//   gnt_a/b    registered ownership grants (never both high)
//   sel        registered mux select, 0 = a, 1 = b
//   out        sel ? b : a while owned, 0 when idle (combinational)
//   out_valid  gnt_a | gnt_b
module mux_arbiter #(
  parameter int WIDTH    = 3,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t state, nxt;
  logic   last_b;   // 1: B was the most recent owner, so A wins the next tie
  logic   expire_a; // A must give way to a waiting B
  logic   expire_b; // B must give way to a waiting A

  // A hold limit below 2 would let a requester be preempted on entry.
  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("mux_arbiter: MAX_HOLD must be >= 2");
  end

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

  // Cycles spent in the current OWN state; reaches HOLD_MAX on the
  // MAX_HOLD-th cycle of ownership and saturates there.
  logic [HW-1:0] hold_cnt;

  assign expire_a = (state == OWN_A) && (hold_cnt == HOLD_MAX) && req_b;
  assign expire_b = (state == OWN_B) && (hold_cnt == HOLD_MAX) && req_a;
`else
  assign expire_a = 1'b0;
  assign expire_b = 1'b0;
`endif

  // Next-state decode. Handover between owners is direct, with no idle bubble.
  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (req_a && (!req_b || last_b)) nxt = OWN_A;
        else if (req_b)                  nxt = OWN_B;
      end
      OWN_A: begin
        if (!req_a || expire_a) nxt = req_b ? OWN_B : IDLE;
      end
      OWN_B: begin
        if (!req_b || expire_b) nxt = req_a ? OWN_A : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt_a  <= 1'b0;
      gnt_b  <= 1'b0;
      sel    <= 1'b0;
      last_b <= 1'b1;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= '0;
`endif
    end else begin
      state <= nxt;
      gnt_a <= (nxt == OWN_A);
      gnt_b <= (nxt == OWN_B);
      sel   <= (nxt == OWN_B);
      if (nxt == OWN_A && state != OWN_A) last_b <= 1'b0;
      if (nxt == OWN_B && state != OWN_B) last_b <= 1'b1;
`ifdef ARB_TIMEOUT_EN
      if (nxt != state)
        hold_cnt <= '0;
      else if (state != IDLE && hold_cnt != HOLD_MAX)
        hold_cnt <= hold_cnt + 1'b1;
`endif
    end
  end

  assign out_valid = gnt_a | gnt_b;
  assign out       = out_valid ? (sel ? b : a) : '0;

endmodule

// File: tb/tb_mux_arbiter.sv
module tb_mux_arbiter;
  localparam int WIDTH    = 3;
  localparam int MAX_HOLD = 8;

  logic             clk = 1'b0;
  logic             rst, req_a, req_b;
  logic [WIDTH-1:0] a, b, out;
  logic             gnt_a, gnt_b, sel, out_valid;

  int vectors = 0;
  int errs    = 0;

  // reference model: owner 0 = none, 1 = A, 2 = B
  int m_owner = 0;
  int m_last  = 2;
  int m_held  = 0;

  always #5 clk = ~clk;

  mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel), .out(out), .out_valid(out_valid)
  );

  // Apply inputs, take one rising edge, advance the model, settle 1 time unit.
  task automatic cyc(input logic r, input logic ra, input logic rb,
                     input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db);
    int mine, other, peer;
    rst = r; req_a = ra; req_b = rb; a = da; b = db;
    @(posedge clk);
    if (r) begin
      m_owner = 0; m_last = 2; m_held = 0;
    end else if (m_owner == 0) begin
      if (ra && rb)  m_owner = (m_last == 1) ? 2 : 1;
      else if (ra)   m_owner = 1;
      else if (rb)   m_owner = 2;
      if (m_owner != 0) begin m_last = m_owner; m_held = 0; end
    end else begin
      mine  = (m_owner == 1) ? int'(ra) : int'(rb);
      other = (m_owner == 1) ? int'(rb) : int'(ra);
      peer  = (m_owner == 1) ? 2 : 1;
      if (mine == 0) begin
        m_owner = (other != 0) ? peer : 0;
        m_held  = 0;
        if (m_owner != 0) m_last = m_owner;
      end
`ifdef ARB_TIMEOUT_EN
      else if (other != 0 && m_held >= MAX_HOLD - 1) begin
        m_owner = peer; m_last = peer; m_held = 0;
      end
`endif
      else m_held++;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [WIDTH+3:0] got;
    cyc(1, 1, 1, 3'b111, 3'b101);
    cyc(1, 1, 1, 3'b111, 3'b101);
    got = {gnt_a, gnt_b, sel, out_valid, out};
    vectors++;
    if (got !== 7'b0000_000) begin
      errs++; $display("FAIL reset_state: got %b expected %b", got, 7'b0000_000);
    end
    // reset while B owns the mux
    cyc(0, 0, 1, 3'b010, 3'b101);
    got = {gnt_a, gnt_b, sel, out_valid, out};
    vectors++;
    if (got !== 7'b0111_101) begin
      errs++; $display("FAIL own_b_before_rst: got %b expected %b", got, 7'b0111_101);
    end
    cyc(1, 0, 1, 3'b010, 3'b101);
    got = {gnt_a, gnt_b, sel, out_valid, out};
    vectors++;
    if (got !== 7'b0000_000) begin
      errs++; $display("FAIL rst_mid_grant: got %b expected %b", got, 7'b0000_000);
    end
  endtask

  task automatic test_idle();
    logic [WIDTH+3:0] got;
    cyc(1, 0, 0, 3'b000, 3'b000);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 3'($urandom), 3'($urandom));
      got = {gnt_a, gnt_b, sel, out_valid, out};
      vectors++;
      if (got !== 7'b0000_000) begin
        errs++; $display("FAIL idle_cycle_%0d: got %b expected %b", i, got, 7'b0000_000);
      end
    end
  endtask

  task automatic test_single();
    logic [WIDTH+3:0] got;
    cyc(1, 0, 0, 3'b000, 3'b000);
    for (int e = 0; e < 4; e++) begin
      cyc(0, 1, 0, 3'b110, 3'b001);
      got = {gnt_a, gnt_b, sel, out_valid, out};
      vectors++;
      if (got !== 7'b1001_110) begin
        errs++; $display("FAIL single_own_a_edge%0d: got %b expected %b", e, got, 7'b1001_110);
      end
    end
    // req drops: grant still held for this cycle
    req_a = 1'b0;
    #1;
    got = {gnt_a, gnt_b, sel, out_valid, out};
    vectors++;
    if (got !== 7'b1001_110) begin
      errs++; $display("FAIL release_latency: got %b expected %b", got, 7'b1001_110);
    end
    cyc(0, 0, 0, 3'b110, 3'b001);
    got = {gnt_a, gnt_b, sel, out_valid, out};
    vectors++;
    if (got !== 7'b0000_000) begin
      errs++; $display("FAIL single_release: got %b expected %b", got, 7'b0000_000);
    end
  endtask

  task automatic test_tie();
    logic [WIDTH+3:0] got;
    cyc(1, 0, 0, 3'b000, 3'b000);
    cyc(0, 1, 1, 3'b011, 3'b100);
    got = {gnt_a, gnt_b, sel, out_valid, out};
    vectors++;
    if (got !== 7'b1001_011) begin
      errs++; $display("FAIL tie_after_reset: got %b expected %b", got, 7'b1001_011);
    end
    cyc(0, 0, 1, 3'b011, 3'b100);
    got = {gnt_a, gnt_b, sel, out_valid, out};
    vectors++;
    if (got !== 7'b0111_100) begin
      errs++; $display("FAIL tie_drop_a_to_b: got %b expected %b", got, 7'b0111_100);
    end
    cyc(0, 0, 0, 3'b011, 3'b100);
    cyc(0, 1, 1, 3'b011, 3'b100);
    got = {gnt_a, gnt_b, sel, out_valid, out};
    vectors++;
    if (got !== 7'b1001_011) begin
      errs++; $display("FAIL tie_round_robin_a: got %b expected %b", got, 7'b1001_011);
    end
    cyc(0, 0, 0, 3'b011, 3'b100);
    cyc(0, 1, 1, 3'b011, 3'b100);
    got = {gnt_a, gnt_b, sel, out_valid, out};
    vectors++;
    if (got !== 7'b0111_100) begin
      errs++; $display("FAIL tie_round_robin_b: got %b expected %b", got, 7'b0111_100);
    end
  endtask

  task automatic test_handover();
    logic [WIDTH+3:0] got;
    cyc(1, 0, 0, 3'b000, 3'b000);
    cyc(0, 1, 0, 3'b001, 3'b110);
    cyc(0, 0, 1, 3'b001, 3'b110);
    got = {gnt_a, gnt_b, sel, out_valid, out};
    vectors++;
    if (got !== 7'b0111_110) begin
      errs++; $display("FAIL handover_a_to_b: got %b expected %b", got, 7'b0111_110);
    end
    cyc(0, 1, 0, 3'b001, 3'b110);
    got = {gnt_a, gnt_b, sel, out_valid, out};
    vectors++;
    if (got !== 7'b1001_001) begin
      errs++; $display("FAIL handover_b_to_a: got %b expected %b", got, 7'b1001_001);
    end
  endtask

  task automatic test_timeout();
    logic [WIDTH+3:0] got, exp;
    cyc(1, 0, 0, 3'b000, 3'b000);
    cyc(0, 1, 0, 3'b011, 3'b100);  // OWN_A entry edge
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 1, 1, 3'b011, 3'b100);
`ifdef ARB_TIMEOUT_EN
      exp = (k == 8) ? 7'b0111_100 : 7'b1001_011;
`else
      exp = 7'b1001_011;
`endif
      got = {gnt_a, gnt_b, sel, out_valid, out};
      vectors++;
      if (got !== exp) begin
        errs++; $display("FAIL timeout_edge%0d: got %b expected %b", k, got, exp);
      end
    end
`ifdef ARB_TIMEOUT_EN
    // B drops; preempted A still requesting gets the mux back
    cyc(0, 1, 0, 3'b011, 3'b100);
    exp = 7'b1001_011;
`else
    cyc(0, 0, 1, 3'b011, 3'b100);
    exp = 7'b0111_100;
`endif
    got = {gnt_a, gnt_b, sel, out_valid, out};
    vectors++;
    if (got !== exp) begin
      errs++; $display("FAIL timeout_after: got %b expected %b", got, exp);
    end
  endtask

  task automatic test_random();
    logic [WIDTH+3:0] got, exp;
    logic ra, rb, r;
    ra = 1'b0; rb = 1'b0;
    cyc(1, 0, 0, 3'b000, 3'b000);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) ra = ~ra;
      if ($urandom_range(7) == 0) rb = ~rb;
      r = ($urandom_range(59) == 0);
      cyc(r, ra, rb, 3'($urandom), 3'($urandom));
      exp = {m_owner == 1, m_owner == 2, m_owner == 2, m_owner != 0,
             (m_owner == 1) ? a : ((m_owner == 2) ? b : 3'b000)};
      got = {gnt_a, gnt_b, sel, out_valid, out};
      vectors++;
      if (got !== exp) begin
        errs++; $display("FAIL random_cycle_%0d: got %b expected %b", i, got, exp);
      end
      vectors++;
      if ((gnt_a & gnt_b) !== 1'b0) begin
        errs++; $display("FAIL random_exclusive_%0d: gnt_a=%b gnt_b=%b expected not both", i, gnt_a, gnt_b);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; a = '0; b = '0;
    test_reset();
    test_idle();
    test_single();
    test_tie();
    test_handover();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
